// File: rtl/pad_serial_mult_link.sv
`default_nettype none
// ============================================================================
// Module      : pad_serial_mult_link
// Description : Bit-serial pad front end for the 16x16 approximate multiplier.
//               Shifts in operands A/B, runs a start/done handshake, shifts
//               the product out as two parallel half-width streams.
//               Optional macro SER_PARITY_EN adds an even-parity bit per lane.
// Revision    : 1.0 - initial release
// ============================================================================
module pad_serial_mult_link #(
    parameter int WIDTH       = 16,
    parameter int MUL_TIMEOUT = 64
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 ser_sel_i,
    input  logic                 ser_a_i,
    input  logic                 ser_b_i,
    output logic                 ser_p_lo_o,
    output logic                 ser_p_hi_o,
    output logic                 ser_valid_o,
    output logic [WIDTH-1:0]     mul_a_o,
    output logic [WIDTH-1:0]     mul_b_o,
    output logic                 mul_start_o,
    input  logic [2*WIDTH-1:0]   mul_p_i,
    input  logic                 mul_done_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

`ifdef SER_PARITY_EN
    localparam int c_LOAD_BITS   = WIDTH + 1;
    localparam int c_UNLOAD_BITS = WIDTH + 1;
`else
    localparam int c_LOAD_BITS   = WIDTH;
    localparam int c_UNLOAD_BITS = WIDTH;
`endif
    localparam int c_CNT_W = $clog2(WIDTH + 2);
    localparam int c_TMO_W = $clog2(MUL_TIMEOUT + 1);

    localparam logic [c_CNT_W-1:0] c_LOAD_LAST   = c_CNT_W'(c_LOAD_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_UNLOAD_LAST = c_CNT_W'(c_UNLOAD_BITS - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST    = c_TMO_W'(MUL_TIMEOUT - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD   = 3'd1;
    localparam logic [2:0] c_MUL    = 3'd2;
    localparam logic [2:0] c_UNLOAD = 3'd3;
    localparam logic [2:0] c_REARM  = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_TMO_W-1:0]   r_tmo;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_p;
    logic                 r_ser_lo;
    logic                 r_ser_hi;
    logic                 r_ser_valid;
    logic                 r_done;
    logic                 r_err;

    logic                 w_load_end;
    logic                 w_timeout;
    logic                 w_unload_last;
    logic                 w_data_bit;
    logic                 w_par_bad;

    assign w_load_end    = (r_state == c_LOAD) && ser_sel_i && (r_cnt == c_LOAD_LAST);
    assign w_timeout     = (r_state == c_MUL) && !mul_done_i && (r_tmo == c_TMO_LAST);
    assign w_unload_last = (r_state == c_UNLOAD) && (r_cnt == c_UNLOAD_LAST);

`ifdef SER_PARITY_EN
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(WIDTH - 1);

    logic r_par_lo;
    logic r_par_hi;

    // The bit arriving at count WIDTH is the lane parity, not operand data
    assign w_data_bit = (r_cnt <= c_DATA_LAST);
    assign w_par_bad  = w_load_end && (((^r_a) ^ ser_a_i) || ((^r_b) ^ ser_b_i));
`else
    assign w_data_bit = 1'b1;
    assign w_par_bad  = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (ser_sel_i) w_next_state = c_LOAD;
            end
            c_LOAD: begin
                if (!ser_sel_i || w_par_bad) w_next_state = c_REARM;
                else if (w_load_end)         w_next_state = c_MUL;
            end
            c_MUL: begin
                if (mul_done_i)     w_next_state = c_UNLOAD;
                else if (w_timeout) w_next_state = c_REARM;
            end
            c_UNLOAD: begin
                if (w_unload_last) w_next_state = c_REARM;
            end
            c_REARM: begin
                if (!ser_sel_i) w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (r_state != c_IDLE);
        mul_start_o = (r_state == c_MUL) && (r_tmo == '0);
    end

    // r_p keeps only the bits still to be sent; bit 0 of each half leaves at capture
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_p         <= '0;
            r_ser_lo    <= 1'b0;
            r_ser_hi    <= 1'b0;
            r_ser_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef SER_PARITY_EN
            r_par_lo    <= 1'b0;
            r_par_hi    <= 1'b0;
`endif
        end else begin
            r_ser_lo    <= 1'b0;
            r_ser_hi    <= 1'b0;
            r_ser_valid <= 1'b0;
            r_done      <= 1'b0;

            if (r_state == c_MUL) r_tmo <= r_tmo + 1'b1;
            else                  r_tmo <= '0;

            case (r_state)
                c_IDLE: begin
                    if (ser_sel_i) begin
                        r_a   <= {ser_a_i, {(WIDTH-1){1'b0}}};
                        r_b   <= {ser_b_i, {(WIDTH-1){1'b0}}};
                        r_cnt <= c_CNT_W'(1);
                        r_err <= 1'b0;
                    end
                end
                c_LOAD: begin
                    if (ser_sel_i) begin
                        if (w_data_bit) begin
                            r_a <= {ser_a_i, r_a[WIDTH-1:1]};
                            r_b <= {ser_b_i, r_b[WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (w_par_bad) r_err <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                c_MUL: begin
                    if (mul_done_i) begin
                        r_p         <= {1'b0, mul_p_i[2*WIDTH-1:WIDTH+1],
                                        1'b0, mul_p_i[WIDTH-1:1]};
                        r_cnt       <= '0;
                        r_ser_lo    <= mul_p_i[0];
                        r_ser_hi    <= mul_p_i[WIDTH];
                        r_ser_valid <= 1'b1;
`ifdef SER_PARITY_EN
                        r_par_lo    <= ^mul_p_i[WIDTH-1:0];
                        r_par_hi    <= ^mul_p_i[2*WIDTH-1:WIDTH];
`endif
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                c_UNLOAD: begin
                    if (w_unload_last) begin
                        r_done <= 1'b1;
                    end else begin
                        r_cnt       <= r_cnt + 1'b1;
                        r_p         <= {1'b0, r_p[2*WIDTH-1:WIDTH+1],
                                        1'b0, r_p[WIDTH-1:1]};
                        r_ser_valid <= 1'b1;
`ifdef SER_PARITY_EN
                        if (r_cnt == c_DATA_LAST) begin
                            r_ser_lo <= r_par_lo;
                            r_ser_hi <= r_par_hi;
                        end else
`endif
                        begin
                            r_ser_lo <= r_p[0];
                            r_ser_hi <= r_p[WIDTH];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ser_p_lo_o  = r_ser_lo;
    assign ser_p_hi_o  = r_ser_hi;
    assign ser_valid_o = r_ser_valid;
    assign mul_a_o     = r_a;
    assign mul_b_o     = r_b;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pad_serial_mult_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_pad_serial_mult_link
// Description : Self-checking bench for pad_serial_mult_link; expected products
//               are queued at stimulus time and compared as streams unload.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pad_serial_mult_link;

    localparam int c_W = 16;
`ifdef SER_PARITY_EN
    localparam int c_NB = c_W + 1;
`else
    localparam int c_NB = c_W;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel   = 1'b0;
    logic        sa    = 1'b0;
    logic        sb    = 1'b0;
    logic        done_en = 1'b1;
    logic        lo, hi, valid, start, busy, done, err;
    logic [15:0] ma, mb;
    logic [31:0] mp;

    int          n_chk   = 0;
    int          n_err   = 0;
    int          n_start = 0;
    int          n_valid = 0;
    int          vcnt    = 0;
    logic [16:0] acc_lo  = '0;
    logic [16:0] acc_hi  = '0;
    logic [31:0] mon_exp;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // Exact multiplier stand-in
    assign mp = {16'h0, ma} * {16'h0, mb};

    pad_serial_mult_link #(.WIDTH(16), .MUL_TIMEOUT(64)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .ser_sel_i   (sel),
        .ser_a_i     (sa),
        .ser_b_i     (sb),
        .ser_p_lo_o  (lo),
        .ser_p_hi_o  (hi),
        .ser_valid_o (valid),
        .mul_a_o     (ma),
        .mul_b_o     (mb),
        .mul_start_o (start),
        .mul_p_i     (mp),
        .mul_done_i  (done_en),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Collect each unload burst and compare it against the oldest queued product
    always @(negedge clk) begin
        if (rst_n) begin
            if (start) n_start++;
            if (valid) begin
                n_valid++;
                if (vcnt < 17) begin
                    acc_lo[vcnt] = lo;
                    acc_hi[vcnt] = hi;
                end
                vcnt++;
            end else if (vcnt != 0) begin
                chk_eq("unload_len", 32'(vcnt), 32'(c_NB));
                chk_eq("done_pulse", 32'(done), 32'd1);
                chk_eq("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk_eq("lo_stream", 32'(acc_lo[15:0]), 32'(mon_exp[15:0]));
                    chk_eq("hi_stream", 32'(acc_hi[15:0]), 32'(mon_exp[31:16]));
`ifdef SER_PARITY_EN
                    chk_eq("lo_parity", 32'(acc_lo[16]), 32'(^mon_exp[15:0]));
                    chk_eq("hi_parity", 32'(acc_hi[16]), 32'(^mon_exp[31:16]));
`endif
                end
                vcnt = 0;
            end
        end
    end

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input int nbits,
                              input logic pa, input logic pb, input logic hold);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            sel = 1'b1;
            sa  = (i < c_W) ? a[i[3:0]] : pa;
            sb  = (i < c_W) ? b[i[3:0]] : pb;
        end
        @(negedge clk);
        sel = hold;
        sa  = 1'b0;
        sb  = 1'b0;
    endtask

    task automatic full_frame(input logic [15:0] a, input logic [15:0] b);
        exp_q.push_back({16'h0, a} * {16'h0, b});
        send_frame(a, b, c_NB, ^a, ^b, 1'b0);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk_eq(tag, 32'(done), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_eq("rst_ctrl", 32'({lo, hi, valid, start, busy, done, err}), 32'd0);
        chk_eq("rst_ab", {ma, mb}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 3 x 5, done in the start cycle
        n_start = 0;
        full_frame(16'h0003, 16'h0005);
        chk_eq("t1_start", 32'(start), 32'd1);
        @(negedge clk);
        chk_eq("t1_latency", 32'(valid), 32'd1);
        wait_done("t1_done");
        chk_eq("t1_start_cnt", 32'(n_start), 32'd1);
        chk_eq("t1_err", 32'(err), 32'd0);
        chk_eq("t1_mul_a", 32'(ma), 32'h0003);
        @(negedge clk);
        chk_eq("t1_idle", 32'(busy), 32'd0);

        // Full-scale operands
        n_valid = 0;
        full_frame(16'hFFFF, 16'hFFFF);
        wait_done("t2_done");
        chk_eq("t2_mul_ab", {ma, mb}, 32'hFFFF_FFFF);
        chk_eq("t2_valid_cycles", 32'(n_valid), 32'(c_NB));

        // Short frame: 8 bits then select drops
        @(negedge clk);
        n_start = 0;
        n_valid = 0;
        send_frame(16'hABCD, 16'h1234, 8, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk_eq("t3_err", 32'(err), 32'd1);
        chk_eq("t3_no_start", 32'(n_start), 32'd0);
        chk_eq("t3_no_valid", 32'(n_valid), 32'd0);
        chk_eq("t3_idle", 32'(busy), 32'd0);
        full_frame(16'h0002, 16'h0003);
        wait_done("t3_recover_done");
        chk_eq("t3_err_cleared", 32'(err), 32'd0);

        // Multiplier never answers; select held high afterwards
        @(negedge clk);
        done_en = 1'b0;
        n_start = 0;
        send_frame(16'h0001, 16'h0001, c_NB, 1'b1, 1'b1, 1'b1);
        chk_eq("t4_err_start", 32'(err), 32'd0);
        repeat (63) @(negedge clk);
        chk_eq("t4_err_63", 32'(err), 32'd0);
        @(negedge clk);
        chk_eq("t4_err_64", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        chk_eq("t4_busy_held", 32'(busy), 32'd1);
        chk_eq("t4_start_cnt", 32'(n_start), 32'd1);
        sel = 1'b0;
        @(negedge clk);
        chk_eq("t4_busy_fall", 32'(busy), 32'd0);
        done_en = 1'b1;

        // Asynchronous reset in the middle of LOAD
        send_frame(16'hFFFF, 16'hFFFF, 10, 1'b0, 1'b0, 1'b1);
        chk_eq("t5_busy_pre", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("t5_rst_ctrl", 32'({lo, hi, valid, start, busy, done, err}), 32'd0);
        chk_eq("t5_rst_ab", {ma, mb}, 32'd0);
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        full_frame(16'h0007, 16'h0009);
        wait_done("t5_done");
        chk_eq("t5_err", 32'(err), 32'd0);

`ifdef SER_PARITY_EN
        // Wrong parity on lane A, then the same frame with correct parity
        @(negedge clk);
        n_start = 0;
        send_frame(16'h0001, 16'h0001, c_NB, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk_eq("t6_par_err", 32'(err), 32'd1);
        chk_eq("t6_no_start", 32'(n_start), 32'd0);
        full_frame(16'h0001, 16'h0001);
        wait_done("t6_done");
        chk_eq("t6_err_cleared", 32'(err), 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/pad_serial_mult_link.md
Name: pad_serial_mult_link

Overview:
- Bit-serial pad front end for the 16x16 approximate multiplier in the user project wrapper.
- Deserialises operands A and B from two input pads under a frame-select pad.
- Hands the operands to the multiplier with a start/done handshake, then serialises the 32-bit product out on two output pads, low half and high half in parallel.
- Sits between the io_in/io_out pads and the multiplier instance; it is the pad-path counterpart to the Wishbone register path.

Parameters:
- WIDTH, 16, operand width in bits; the product is 2*WIDTH bits.
- MUL_TIMEOUT, 64, maximum cycles to wait for mul_done_i after mul_start_o.

Ports:
- wb_clk_i  in  1  single clock, rising edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- ser_sel_i  in  1  frame select pad (io_in[3]); high while an operand frame is being shifted in.
- ser_a_i  in  1  operand A serial bit (io_in[0]), LSB first.
- ser_b_i  in  1  operand B serial bit (io_in[1]), LSB first.
- ser_p_lo_o  out  1  product low-half serial bit (io_out[0]), LSB first.
- ser_p_hi_o  out  1  product high-half serial bit (io_out[1]), LSB first.
- ser_valid_o  out  1  high while ser_p_lo_o and ser_p_hi_o carry valid bits.
- mul_a_o  out  WIDTH  operand A to the multiplier.
- mul_b_o  out  WIDTH  operand B to the multiplier.
- mul_start_o  out  1  one-cycle start pulse to the multiplier.
- mul_p_i  in  2*WIDTH  product from the multiplier.
- mul_done_i  in  1  product valid; may be high in the same cycle as mul_start_o.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse after the last product bit.
- err_o  out  1  sticky error flag; cleared by the first bit of the next frame.

Behaviour:
- Reset (wb_rst_ni low, asynchronous):
  - State goes to IDLE; all counters, the A, B and P registers, and every output are 0.
  - Takes effect immediately, in any state including mid-frame.
- States: IDLE, LOAD, MUL, UNLOAD, REARM.
- IDLE:
  - The first cycle with ser_sel_i=1 carries bit 0.
  - That cycle captures A[0]=ser_a_i and B[0]=ser_b_i, sets bit count cnt=1, clears err_o and enters LOAD.
- LOAD:
  - Each cycle with ser_sel_i=1 captures A[cnt] and B[cnt] and increments cnt.
  - All WIDTH bits are captured, including bit WIDTH-1.
  - After bit WIDTH-1 is captured, go to MUL.
  - If ser_sel_i=0 before WIDTH bits: set err_o=1, do not pulse mul_start_o, go to REARM.
- MUL:
  - mul_start_o=1 in the first MUL cycle only.
  - On any MUL cycle with mul_done_i=1 (including the start cycle), capture P<=mul_p_i, set cnt=0 and go to UNLOAD.
  - Timeout counter starts at the start pulse. If MUL_TIMEOUT cycles pass with no mul_done_i: set err_o=1 and go to REARM.
  - mul_done_i is ignored in every other state.
- UNLOAD:
  - Lasts exactly WIDTH cycles.
  - In the k-th cycle (k=0..WIDTH-1), outputs are registered: ser_p_lo_o=P[k], ser_p_hi_o=P[WIDTH+k], ser_valid_o=1.
  - After k=WIDTH-1, pulse done_o for one cycle (the first REARM cycle) and go to REARM.
  - ser_sel_i is ignored during MUL and UNLOAD.
- REARM:
  - Stay until ser_sel_i is sampled 0, then go to IDLE.
  - A frame select held high never starts a second frame.
- Outside UNLOAD: ser_p_lo_o, ser_p_hi_o and ser_valid_o are 0.
- mul_a_o and mul_b_o drive the A and B registers directly. They hold their value from the end of LOAD until the next frame's bit 0.
- Latency: with the multiplier's done asserted in the start cycle, the first product bit appears 2 cycles after the last operand bit.
- No arithmetic is performed in this block; the width split of P is fixed at WIDTH.

Optional Feature:
- Macro: SER_PARITY_EN.
- When defined:
  - LOAD takes WIDTH+1 bits per lane; bit WIDTH is an even-parity bit over that lane's WIDTH data bits.
  - After the parity bit, if either lane mismatches: set err_o=1, skip MUL and go to REARM.
  - During UNLOAD, one extra cycle k=WIDTH outputs the even parity of each product half, with ser_valid_o=1.
- When undefined: exactly the behaviour above; no parity bits exist.

Test Plan:
- Frame A=0x0003, B=0x0005, multiplier done in start cycle -> mul_start_o pulses once; lo stream LSB-first = 0x000F, hi stream = 0x0000; done_o pulses; err_o=0.
- A=0xFFFF, B=0xFFFF -> mul_a_o=0xFFFF (bit 15 captured); lo stream = 0x0001, hi stream = 0xFFFE; ser_valid_o high for exactly 16 cycles.
- ser_sel_i drops after 8 bits -> err_o=1, no mul_start_o, no ser_valid_o; next full frame (A=2, B=3) clears err_o and outputs lo=0x0006.
- mul_done_i held 0 -> err_o=1 exactly 64 cycles after mul_start_o; busy_o falls once ser_sel_i=0.
- wb_rst_ni pulsed low at LOAD bit 10 -> all outputs 0 asynchronously; next frame A=7, B=9 yields lo=0x003F.
- SER_PARITY_EN defined: A=0x0001 sent with parity bit 0 -> err_o=1, no mul_start_o; with parity bit 1 -> normal unload followed by parity bits (lo half parity 1 for P=0x0001).
